// File: rtl/sm_imem_loader.sv
// sm_imem_loader: receives a framed byte stream (A5, N lo, N hi, N LE words),
// writes the words into instruction memory and holds the CPU in reset while loading.
module sm_imem_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int TIMEOUT    = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rxData,
  input  logic                  rxValid,
  output logic                  rxReady,
  output logic                  imWe,
  output logic [ADDR_WIDTH-1:0] imWAddr,
  output logic [31:0]           imWData,
  output logic                  cpuRst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE
  } state_t;

  state_t                r_state, w_next;
  logic [15:0]           r_len;
  logic [1:0]            r_idx;
  logic [31:0]           r_word;
  logic [ADDR_WIDTH:0]   r_addr;
  logic [CW-1:0]         r_cnt;
  logic                  r_cpuRst_n, r_err;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [31:0]           r_wdata;

  logic        w_acc, w_cnting, w_tmo, w_set_err, w_clr_err;
  logic [15:0] w_n;
  logic [16:0] w_addr_inc;

  assign rxReady    = (r_state != S_WRITE) && (r_state != S_DONE);
  assign w_acc      = rxValid & rxReady;
  assign w_n        = {rxData, r_len[7:0]};
  assign w_addr_inc = 17'(r_addr) + 17'd1;
  assign w_cnting   = (r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA);
  // an accepted byte on the same edge always beats the timeout
  assign w_tmo      = w_cnting && !w_acc && (r_cnt == CW'(TIMEOUT - 1));

  // next-state logic plus error set/clear strobes
  always_comb begin
    w_next    = r_state;
    w_set_err = 1'b0;
    w_clr_err = 1'b0;
    case (r_state)
      S_IDLE:
        if (w_acc && rxData == 8'hA5) begin
          w_next    = S_LEN0;
          w_clr_err = 1'b1;
        end
      S_LEN0:
        if (w_acc) w_next = S_LEN1;
        else if (w_tmo) begin w_next = S_IDLE; w_set_err = 1'b1; end
      S_LEN1:
        if (w_acc) begin
          if (w_n == 16'd0) w_next = S_DONE;
          else if (17'(w_n) > 17'(DEPTH)) begin w_next = S_IDLE; w_set_err = 1'b1; end
          else w_next = S_DATA;
        end else if (w_tmo) begin w_next = S_IDLE; w_set_err = 1'b1; end
      S_DATA:
        if (w_acc) begin
          if (r_idx == 2'd3) w_next = S_WRITE;
        end else if (w_tmo) begin w_next = S_IDLE; w_set_err = 1'b1; end
      S_WRITE:
        w_next = (w_addr_inc == {1'b0, r_len}) ? S_DONE : S_DATA;
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;

  // frame length, byte assembly, write address/data capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_len   <= '0;
      r_idx   <= '0;
      r_word  <= '0;
      r_addr  <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      if (r_state == S_IDLE && w_next == S_LEN0) begin
        r_addr <= '0;
        r_idx  <= '0;
      end
      if (r_state == S_LEN0 && w_acc) r_len[7:0]  <= rxData;
      if (r_state == S_LEN1 && w_acc) r_len[15:8] <= rxData;
      if (r_state == S_DATA && w_acc) begin
        r_idx  <= r_idx + 2'd1;  // wraps to 0 after the 4th byte
        r_word <= {rxData, r_word[31:8]};
        if (r_idx == 2'd3) begin
          r_wdata <= {rxData, r_word[31:8]};
          r_waddr <= r_addr[ADDR_WIDTH-1:0];
        end
      end
      if (r_state == S_WRITE) r_addr <= r_addr + 1'b1;
    end

  // inactivity counter: clears on accepted byte and on any state change
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                    r_cnt <= '0;
    else if (w_cnting && !w_acc && w_next == r_state) r_cnt <= r_cnt + 1'b1;
    else                                           r_cnt <= '0;

  // CPU reset and sticky error flops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cpuRst_n <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_clr_err)             r_cpuRst_n <= 1'b0;
      else if (w_next == S_IDLE) r_cpuRst_n <= 1'b1;
      if (w_clr_err)      r_err <= 1'b0;
      else if (w_set_err) r_err <= 1'b1;
    end

  assign imWe     = (r_state == S_WRITE);
  assign imWAddr  = r_waddr;
  assign imWData  = r_wdata;
  assign cpuRst_n = r_cpuRst_n;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign err      = r_err;
endmodule

// File: tb/tb_sm_imem_loader.sv
// Scoreboard bench for sm_imem_loader: expected writes queued by stimulus,
// popped and compared by a negedge monitor whenever imWe is seen.
module tb_sm_imem_loader;
  localparam int AW  = 6;
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rxData;
  logic          rxValid;
  logic          rxReady, imWe, cpuRst_n, busy, done, err;
  logic [AW-1:0] imWAddr;
  logic [31:0]   imWData;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [AW+31:0] exp_q[$];

  sm_imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rxData(rxData), .rxValid(rxValid),
    .rxReady(rxReady), .imWe(imWe), .imWAddr(imWAddr), .imWData(imWData),
    .cpuRst_n(cpuRst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // monitor: every write pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (rst_n && imWe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", imWAddr, imWData);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        if ({imWAddr, imWData} !== e) begin
          errors++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   imWAddr, imWData, e[AW+31:32], e[31:0]);
        end
      end
    end
  end

  // drive one byte, wait (bounded) for acceptance; returns 1ns after the accepting edge
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    rxData  = b;
    rxValid = 1'b1;
    n = 0;
    while (!rxReady && n < 50) begin @(negedge clk); n++; end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout: byte %0h not accepted", b);
    end
    @(posedge clk); #1;
    rxValid = 1'b0;
  endtask

  task automatic expw(input int a, input logic [31:0] d);
    exp_q.push_back({AW'(a), d});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rxValid = 1'b0; rxData = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cpuRst_n", cpuRst_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rxReady", rxReady, 1);
    chk("rst_err", err, 0);
    chk("rst_imWe", imWe, 0);
    chk("rst_imWAddr", 32'(imWAddr), 0);
    chk("rst_imWData", imWData, 0);
    rst_n = 1'b1;
    tick(1);
    chk("cpuRst_n_after_first_edge", cpuRst_n, 1);
    tick(5);
    chk("idle_busy", busy, 0);
    chk("idle_done_cnt", done_cnt, 0);
    send(8'h00, 1); send(8'h12, 1);
    chk("junk_busy", busy, 0);
    chk("junk_cpuRst_n", cpuRst_n, 1);

    // two-word frame with gaps
    expw(0, 32'h12345678); expw(1, 32'hDEADBEEF);
    send(8'hA5, 2);
    chk("sync_cpuRst_n", cpuRst_n, 0);
    chk("sync_busy", busy, 1);
    send(8'h02, 1); send(8'h00, 2);
    send(8'h78, 1); send(8'h56, 3); send(8'h34, 1); send(8'h12, 1);
    send(8'hEF, 2); send(8'hBE, 1); send(8'hAD, 1); send(8'hDE, 1);
    chk("last_write_cpuRst_n", cpuRst_n, 0);
    chk("write_rxReady", rxReady, 0);
    tick(1);
    chk("done_cpuRst_n", cpuRst_n, 0);
    chk("done_pulse", done, 1);
    tick(1);
    chk("frameA_cpuRst_n", cpuRst_n, 1);
    chk("frameA_busy", busy, 0);
    chk("frameA_done_cnt", done_cnt, 1);
    chk("hold_imWAddr", 32'(imWAddr), 1);
    chk("hold_imWData", imWData, 32'hDEADBEEF);

    // empty frame
    send(8'hA5, 1); send(8'h00, 0); send(8'h00, 0);
    chk("empty_done", done, 1);
    tick(1);
    chk("empty_cpuRst_n", cpuRst_n, 1);
    chk("empty_done_cnt", done_cnt, 2);

    // oversize frame N = 65
    send(8'hA5, 1); send(8'h41, 0); send(8'h00, 0);
    chk("over_err", err, 1);
    chk("over_busy", busy, 0);
    chk("over_cpuRst_n", cpuRst_n, 1);
    tick(3);
    chk("over_err_sticky", err, 1);
    // following valid frame clears err
    expw(0, 32'h11223344);
    send(8'hA5, 1);
    chk("sync_clears_err", err, 0);
    send(8'h01, 0); send(8'h00, 0);
    send(8'h44, 0); send(8'h33, 0); send(8'h22, 0); send(8'h11, 0);
    tick(2);
    chk("recover_cpuRst_n", cpuRst_n, 1);
    chk("recover_done_cnt", done_cnt, 3);

    // N = DEPTH is legal: write all 64 words, last at DEPTH-1
    send(8'hA5, 1); send(8'h40, 0); send(8'h00, 0);
    for (int w = 0; w < 64; w++) begin
      logic [31:0] d;
      d = 32'hA0000000 + 32'(w) * 32'h01010101;
      expw(w, d);
      for (int k = 0; k < 4; k++) send(d[k*8 +: 8], 0);
    end
    tick(2);
    chk("full_err", err, 0);
    chk("full_done_cnt", done_cnt, 4);
    chk("full_last_addr", 32'(imWAddr), 63);

    // timeout in the middle of a word
    send(8'hA5, 1); send(8'h01, 0); send(8'h00, 0); send(8'h78, 0); send(8'h56, 0);
    tick(TMO - 2);
    chk("pre_tmo_busy", busy, 1);
    chk("pre_tmo_err", err, 0);
    tick(5);
    chk("tmo_err", err, 1);
    chk("tmo_cpuRst_n", cpuRst_n, 1);
    chk("tmo_busy", busy, 0);

    // async reset after 6 data bytes of a 2-word frame
    expw(0, 32'hCAFEBABE);
    send(8'hA5, 1); send(8'h02, 0); send(8'h00, 0);
    send(8'hBE, 0); send(8'hBA, 0); send(8'hFE, 0); send(8'hCA, 0);
    send(8'h01, 0); send(8'h02, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cpuRst_n", cpuRst_n, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_imWAddr", 32'(imWAddr), 0);
    chk("mid_rst_imWData", imWData, 0);
    chk("mid_rst_rxReady", rxReady, 1);
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(5);
    chk("post_rst_cpuRst_n", cpuRst_n, 1);
    chk("pending_writes", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sm_imem_loader.md
# sm_imem_loader

Upstream program loader for the schoolMIPS core. It receives a byte stream from a host link, assembles little-endian 32-bit instruction words, and writes them into the instruction memory that the CPU fetches from. While loading, it holds the CPU in reset. It releases the CPU after a complete frame, or after an aborted one.

## Interface
Parameters:
- ADDR_WIDTH, 6, instruction-memory word address width; DEPTH = 2^ADDR_WIDTH words
- TIMEOUT, 1000, max idle cycles between accepted bytes inside a frame (≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- rxData  in  8  incoming byte
- rxValid  in  1  rxData valid
- rxReady  out  1  loader can accept a byte
- imWe  out  1  instruction-memory write enable, one-cycle pulse per word
- imWAddr  out  ADDR_WIDTH  word write address
- imWData  out  32  word write data
- cpuRst_n  out  1  active-low reset to the CPU, registered
- busy  out  1  frame in progress (state ≠ IDLE)
- done  out  1  one-cycle pulse on successful frame completion
- err  out  1  sticky frame error flag

## Operation
- Byte transfer: a byte is accepted on a rising edge where rxValid & rxReady. rxReady = 1 in every state except WRITE and DONE.
- Frame format: sync byte 0xA5, then N as 16-bit little-endian (LEN0 = low byte, LEN1 = high byte), then N words of 4 bytes each. The first byte of each word is bits [7:0].
- States:
  - IDLE
    - A byte other than 0xA5 is accepted and ignored.
    - 0xA5 → LEN0. On this transition: err ← 0, cpuRst_n ← 0, addr ← 0.
  - LEN0: on byte → LEN1, latch N[7:0].
  - LEN1: on byte, latch N[15:8], then:
    - N == 0 → DONE.
    - N > DEPTH → IDLE with err ← 1.
    - Otherwise → DATA, with byte index 0.
  - DATA
    - Shift in bytes to form the word LE.
    - On the 4th byte → WRITE.
  - WRITE
    - imWe = 1 for exactly this cycle, imWAddr = addr, imWData = the assembled word.
    - Next edge: addr ← addr+1.
    - If that was word N → DONE; else → DATA with byte index 0.
  - DONE: done = 1 for one cycle → IDLE.
- cpuRst_n is a dedicated flop:
  - Cleared on the edge entering LEN0.
  - Set on the edge entering IDLE, from DONE or from any abort.
- Timeout:
  - A counter runs in LEN0, LEN1 and DATA, and clears on every accepted byte and on state entry.
  - On reaching TIMEOUT: → IDLE with err ← 1, cpuRst_n ← 1.
  - Words already written stay in memory.
- err is cleared only by reset or by the next accepted 0xA5 in IDLE.
- imWAddr holds its value when imWe = 0. imWData holds the last assembled word.
- Address arithmetic: addr is ADDR_WIDTH+1 bits internally; imWAddr = addr[ADDR_WIDTH-1:0]. N ≤ DEPTH guarantees no wrap.

## Timing
- Reset values (rst_n = 0, asynchronous):
  - state IDLE.
  - cpuRst_n = 0, err = 0, done = 0, imWe = 0, imWAddr = 0, imWData = 0.
  - Byte index, N and timeout counter = 0.
  - busy = 0, rxReady = 1.
- cpuRst_n rises on the first rising edge after rst_n deasserts. The CPU runs from the existing memory contents until a frame arrives.
- Latency:
  - 4th byte of a word accepted at edge t → imWe high from t to t+1.
  - The next byte is acceptable from edge t+1.
- Last word:
  - WRITE in cycle [t, t+1], DONE in [t+1, t+2].
  - cpuRst_n = 1 and busy = 0 from edge t+2.
- Sync accepted at edge s → cpuRst_n = 0 and busy = 1 from s.
- rxReady = 0 in WRITE/DONE. A byte presented then is held by the sender and is not lost.
- rst_n asserted mid-frame: immediate return to IDLE, cpuRst_n = 0, err = 0. No imWe pulse is emitted for a partial word.
- Timeout coinciding with a byte acceptance on the same edge: the byte wins and the counter clears.
- N = DEPTH is legal: the last write goes to imWAddr = DEPTH-1.

## Test plan
- Reset, then idle 5 cycles:
  - cpuRst_n = 0 during reset, 1 after the first edge.
  - imWe, err, done and busy stay 0.
  - Bytes 0x00, 0x12 are ignored (busy stays 0).
- Frame A5 02 00 | 78 56 34 12 | EF BE AD DE, rxValid gaps between bytes:
  - imWe pulses at addr 0 with 0x12345678, then addr 1 with 0xDEADBEEF.
  - done pulses once; cpuRst_n is 0 from the sync byte until 2 edges after the last byte.
- Frame A5 00 00:
  - No imWe.
  - done pulse, then cpuRst_n = 1.
- Frame A5 41 00 with ADDR_WIDTH = 6 (N = 65):
  - err = 1, no writes, return to IDLE, cpuRst_n = 1.
  - A subsequent valid frame clears err.
- Frame A5 01 00 78 56, then silence for TIMEOUT cycles:
  - err = 1, cpuRst_n = 1, no imWe.
- rst_n pulsed after the 6th byte of a 2-word frame:
  - All outputs return to reset values.
  - Only word 0 was written.
